// File: rtl/opstage_pkg.sv
// opstage_pkg: shared widths, ALU_control codes and immediate/ctrl helpers for the operand stage.
package opstage_pkg;
   localparam int DW   = 32;
   localparam int NREG = 32;
   localparam int IMMW = 16;
   localparam int AW   = $clog2(NREG);
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NAND = 4'b1101;

   function automatic logic is_legal_ctrl(input logic [3:0] c);
      return c inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NAND};
   endfunction

   // Arithmetic ops see a signed immediate, logical ops an unsigned one.
   function automatic logic [DW-1:0] ext_imm(input logic [3:0] c, input logic [IMMW-1:0] imm);
      return (c == ALU_ADD || c == ALU_SUB || c == ALU_SLT) ? {{(DW-IMMW){imm[IMMW-1]}}, imm}
                                                          : {{(DW-IMMW){1'b0}}, imm};
   endfunction
endpackage

// File: rtl/op_regfile.sv
// op_regfile: NREG x DW register file, two async read ports, one sync write port, R0 hardwired to 0.
module op_regfile
   import opstage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b
);
   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst)
      if (rst) regs <= '{default: '0};
      else if (we && waddr != '0) regs[waddr] <= wdata;

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch and output slot feeding the ALU.
// OPSTAGE_BYPASS_EN selects write-through bypass; otherwise a writeback hazard costs one stall cycle.
module alu_operand_stage
   import opstage_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [AW-1:0]   rs_i,
   input  logic [AW-1:0]   rt_i,
   input  logic [AW-1:0]   rd_i,
   input  logic [IMMW-1:0] imm_i,
   input  logic            use_imm_i,
   input  logic [3:0]      ctrl_i,
   input  logic            flush_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [DW-1:0]   src1_o,
   output logic [DW-1:0]   src2_o,
   output logic [3:0]      alu_ctrl_o,
   output logic [AW-1:0]   rd_o,
   output logic            illegal_o,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_addr_i,
   input  logic [DW-1:0]   wb_data_i
);
   logic [DW-1:0] rf_a, rf_b, rd_a, rd_b;
   logic          hazard_stall, accept, legal, slot_free;

   op_regfile u_rf (
      .clk(clk_i), .rst(rst_i), .we(wb_we_i), .waddr(wb_addr_i), .wdata(wb_data_i),
      .raddr_a(rs_i), .raddr_b(rt_i), .rdata_a(rf_a), .rdata_b(rf_b)
   );

   assign slot_free = ~ex_valid_o | ex_ready_i;
`ifdef OPSTAGE_BYPASS_EN
   assign rd_a         = (wb_we_i && wb_addr_i == rs_i && rs_i != '0) ? wb_data_i : rf_a;
   assign rd_b         = (wb_we_i && wb_addr_i == rt_i && rt_i != '0) ? wb_data_i : rf_b;
   assign hazard_stall = 1'b0;
`else
   assign rd_a         = rf_a;
   assign rd_b         = rf_b;
   assign hazard_stall = req_valid_i & slot_free & wb_we_i & (wb_addr_i != '0) &
                         ((wb_addr_i == rs_i) | (~use_imm_i & (wb_addr_i == rt_i)));
`endif

   assign req_ready_o = slot_free & ~hazard_stall;
   assign accept      = req_valid_i & req_ready_o;
   assign legal       = is_legal_ctrl(ctrl_i);

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         ex_valid_o <= 1'b0;
         src1_o     <= '0;
         src2_o     <= '0;
         alu_ctrl_o <= '0;
         rd_o       <= '0;
         illegal_o  <= 1'b0;
      end else begin
         illegal_o <= accept & ~legal;
         if (flush_i) ex_valid_o <= 1'b0;
         else if (accept) begin
            ex_valid_o <= legal;
            if (legal) begin
               src1_o     <= rd_a;
               src2_o     <= use_imm_i ? ext_imm(ctrl_i, imm_i) : rd_b;
               alu_ctrl_o <= ctrl_i;
               rd_o       <= rd_i;
            end
         end else if (ex_ready_i) ex_valid_o <= 1'b0;
      end
endmodule
